ysyx_24110006_hazard_ctl: RTL and testbench
===========================================

// Module: ysyx_24110006_hazard_ctl
// PURPOSE
//  In-order scoreboard/issue controller between IDU and EXU/LSU/WBU. Tracks in-flight destination registers in a
//  DEPTH-entry queue, drives the decode-stage stall on RAW hazards, fullness and serialising instructions (CSR/FENCE).
//  Removes wrong-path entries on pipeline flush. Its o_stall feeds the decode stage's stall input.
// PARAMETERS
//  DEPTH  4  max in-flight instructions between issue and writeback (power of 2, >=2)
// PORTS
//  i_clock        in   1          clock; all state updates on posedge
//  i_reset        in   1          synchronous, active-high reset
//  i_issue_valid  in   1          decode stage holds a valid instruction wanting to issue
//  i_issue_rd     in   5          destination register of issuing instruction
//  i_issue_wen    in   1          issuing instruction writes rd
//  i_issue_serial in   1          issuing instruction is CSR/FENCE/mret: may only issue into an empty queue
//  i_rs1          in   5          source register 1
//  i_rs1_used     in   1          rs1 is read by the instruction
//  i_rs2          in   5          source register 2
//  i_rs2_used     in   1          rs2 is read by the instruction
//  i_exu_done     in   1          EXU finished the oldest not-yet-executed entry this cycle
//  i_wb_valid     in   1          WBU retired the oldest entry this cycle (regfile written at this edge)
//  i_flush        in   1          redirect: discard all entries not yet executed
//  o_stall        out  1          issue blocked this cycle (combinational)
//  o_count        out  $clog2(DEPTH)+1  number of valid entries
//  o_empty        out  1          o_count==0
//  o_full         out  1          o_count==DEPTH
// BEHAVIOUR
//  - Reset: queue empty, head/exe/tail pointers 0, o_count=0, o_empty=1, o_full=0, o_stall=0. Reset mid-operation
//    discards all entries at the next edge regardless of other inputs.
//  - Entry = {rd[4:0], wen, exed}. wen stored as i_issue_wen && (i_issue_rd!=0); x0 never creates a hazard.
//  - Three pointers, width $clog2(DEPTH)+1 (MSB = wrap bit): head (oldest), exe (oldest with exed=0), tail.
//    Invariant head<=exe<=tail in queue order; count = tail-head mod 2*DEPTH.
//  - hazard = OR over valid entries e with e.wen: (i_rs1_used && e.rd==i_rs1) || (i_rs2_used && e.rd==i_rs2).
//  - o_stall = i_issue_valid && (hazard || o_full || (i_issue_serial && !o_empty)); all terms from current
//    state only: an entry retiring or executing in the same cycle still counts; no bypass.
//  - push = i_issue_valid && !o_stall && !i_flush; writes entry at tail, exed=0, tail+=1. Full blocks push even
//    with simultaneous pop.
//  - i_exu_done: sets exed on entry at exe, exe+=1. Ignored (and $fatal in sim) when exe==tail.
//  - i_wb_valid: head+=1; only legal for an entry with exed=1 (or marked in the same cycle); $fatal in sim when empty.
//  - i_flush: tail <= exe after this cycle's i_exu_done is applied (the resolving branch itself survives); push
//    suppressed; same-cycle i_wb_valid still pops head.
//  - Priority per edge: reset > (exu_done, wb pop) > flush truncation > push. All updates registered; latency from
//    push to hazard visible = 1 cycle; pop to hazard cleared = 1 cycle.
//  - o_count/o_empty/o_full derived from registered pointers (no combinational path from inputs).
// TESTING
//  1 Reset, push rd=x5 wen, next cycle issue rs1=x5 used -> o_stall=1; after exu_done+wb_valid -> o_stall=0 next cycle.
//  2 Push rd=x0 wen=1, then rs1=x0 used -> o_stall=0; push rd=x7 wen=0, rs2=x7 -> o_stall=0.
//  3 Push 4 non-hazard instrs (DEPTH=4) -> o_full=1, o_count=4, 5th issue stalled even with wb_valid that cycle;
//    o_count=3, o_full=0 next cycle.
//  4 Queue {x1 exed, x2, x3}; exu_done(x2)+i_flush same cycle -> o_count=2, x3 gone, rs1=x3 issue -> o_stall=0.
//  5 Serial issue with o_count=2 -> stalled until both retire; issues cycle o_empty=1; next non-serial issues normally.
//  6 Reset asserted with 3 entries and push/flush active -> next cycle o_count=0, o_empty=1, o_stall follows inputs.

Source files
------------

// File: rtl/ysyx_24110006_hazard_ctl.sv
// In-order issue scoreboard: tracks in-flight destination registers and stalls decode on RAW hazards,
// a full queue, or serialising instructions; flush truncates entries that have not yet executed.
module ysyx_24110006_hazard_ctl #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_issue_valid,
  input  logic [4:0]                 i_issue_rd,
  input  logic                       i_issue_wen,
  input  logic                       i_issue_serial,
  input  logic [4:0]                 i_rs1,
  input  logic                       i_rs1_used,
  input  logic [4:0]                 i_rs2,
  input  logic                       i_rs2_used,
  input  logic                       i_exu_done,
  input  logic                       i_wb_valid,
  input  logic                       i_flush,
  output logic                       o_stall,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry a wrap bit so a full queue is distinguishable from an empty one.
  logic [PW-1:0]    r_head, r_exe, r_tail;
  logic [4:0]       r_rd [DEPTH];
  logic [DEPTH-1:0] r_wen, r_exed;

  logic [PW-1:0] w_count;
  logic [PW-1:0] w_exe_nxt;
  logic [AW-1:0] w_off;
  logic          w_hazard, w_exe_step, w_pop, w_push;

  assign w_count = r_tail - r_head;
  assign o_count = w_count;
  assign o_empty = (w_count == '0);
  assign o_full  = (w_count == PW'(DEPTH));

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    w_hazard = 1'b0;
    w_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = AW'(i) - r_head[AW-1:0];
      if ((PW'(w_off) < w_count) && r_wen[i] &&
          ((i_rs1_used && (r_rd[i] == i_rs1)) || (i_rs2_used && (r_rd[i] == i_rs2))))
        w_hazard = 1'b1;
    end
  end

  assign o_stall    = i_issue_valid && (w_hazard || o_full || (i_issue_serial && !o_empty));
  assign w_exe_step = i_exu_done && (r_exe != r_tail);
  assign w_pop      = i_wb_valid && !o_empty;
  assign w_push     = i_issue_valid && !o_stall && !i_flush;
  assign w_exe_nxt  = r_exe + PW'(w_exe_step);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_head <= '0;
      r_exe  <= '0;
      r_tail <= '0;
      r_wen  <= '0;
      r_exed <= '0;
    end else begin
      if (w_exe_step) r_exed[r_exe[AW-1:0]] <= 1'b1;
      if (w_pop) r_head <= r_head + PW'(1);
      r_exe <= w_exe_nxt;
      // The resolving branch has just executed, so truncating to the advanced exe keeps it.
      if (i_flush) begin
        r_tail <= w_exe_nxt;
      end else if (w_push) begin
        r_tail                 <= r_tail + PW'(1);
        r_wen[r_tail[AW-1:0]]  <= i_issue_wen && (i_issue_rd != 5'd0);
        r_exed[r_tail[AW-1:0]] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset && !i_flush && w_push) r_rd[r_tail[AW-1:0]] <= i_issue_rd;
  end

  // Protocol guards: retire only executed work, execute only issued work.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      if (i_exu_done)
        assert (r_exe != r_tail) else $fatal(1, "exu_done with no unexecuted entry");
      if (i_wb_valid)
        assert (!o_empty && (r_exed[r_head[AW-1:0]] || (i_exu_done && (r_exe == r_head))))
          else $fatal(1, "wb_valid on empty queue or unexecuted entry");
    end
  end
endmodule

// File: tb/tb_ysyx_24110006_hazard_ctl.sv
// Directed and random bench for the hazard controller against a queue-based reference model.
module tb_ysyx_24110006_hazard_ctl;
  logic       clk = 1'b0;
  logic       rst, iv, iwen, iser, rs1u, rs2u, exu, wb, fl;
  logic [4:0] ird, rs1, rs2;
  logic       stall, empty, full;
  logic [2:0] count;

  // Model entry: {rd[4:0], wen, exed}, oldest at index 0.
  logic [6:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  ysyx_24110006_hazard_ctl #(.DEPTH(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_issue_valid(iv), .i_issue_rd(ird), .i_issue_wen(iwen),
    .i_issue_serial(iser), .i_rs1(rs1), .i_rs1_used(rs1u), .i_rs2(rs2), .i_rs2_used(rs2u),
    .i_exu_done(exu), .i_wb_valid(wb), .i_flush(fl),
    .o_stall(stall), .o_count(count), .o_empty(empty), .o_full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_stall();
    bit haz = 0;
    foreach (exp_q[i])
      if (exp_q[i][1] && ((rs1u && exp_q[i][6:2] == rs1) || (rs2u && exp_q[i][6:2] == rs2))) haz = 1;
    return iv && (haz || exp_q.size() == 4 || (iser && exp_q.size() != 0));
  endfunction

  function automatic bit has_unexed();
    foreach (exp_q[i]) if (!exp_q[i][0]) return 1;
    return 0;
  endfunction

  task automatic idle();
    iv = 0; ird = 0; iwen = 0; iser = 0; rs1 = 0; rs1u = 0; rs2 = 0; rs2u = 0;
    exu = 0; wb = 0; fl = 0; rst = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen);
    idle();
    iv = 1; ird = rd; iwen = wen;
  endtask

  // One clock: check stall mid-cycle, advance the model at the edge, check registered outputs after it.
  task automatic tick();
    bit m_stall, m_push;
    @(negedge clk);
    m_stall = model_stall();
    chk("stall", stall, m_stall);
    m_push = iv && !m_stall && !fl;
    @(posedge clk);
    if (rst) exp_q.delete();
    else begin
      if (exu)
        for (int i = 0; i < exp_q.size(); i++)
          if (!exp_q[i][0]) begin exp_q[i][0] = 1'b1; break; end
      if (wb && exp_q.size() > 0) void'(exp_q.pop_front());
      if (fl) while (exp_q.size() > 0 && !exp_q[$][0]) void'(exp_q.pop_back());
      if (m_push) exp_q.push_back({ird, iwen && (ird != 5'd0), 1'b0});
    end
    #1;
    chk("count", count, exp_q.size());
    chk("empty", empty, exp_q.size() == 0);
    chk("full", full, exp_q.size() == 4);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      idle();
      exu = has_unexed();
      wb = 1;
      tick();
      guard++;
    end
    chk("drain_empty", empty, 1);
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    idle();
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_stall", stall, 0);

    // RAW on x5, held through retirement, cleared the cycle after.
    issue(5'd5, 1); tick();
    issue(5'd6, 1); rs1 = 5'd5; rs1u = 1; #1;
    chk("t1_raw_stall", stall, 1);
    exu = 1; wb = 1; #1;
    chk("t1_retire_still_stalls", stall, 1);
    tick();
    exu = 0; wb = 0; #1;
    chk("t1_cleared", stall, 0);
    tick();
    drain();

    // x0 and non-writing rd never hazard.
    issue(5'd0, 1); tick();
    issue(5'd7, 0); rs1 = 5'd0; rs1u = 1; #1;
    chk("t2_x0", stall, 0);
    tick();
    issue(5'd8, 0); rs2 = 5'd7; rs2u = 1; #1;
    chk("t2_nowen", stall, 0);
    tick();
    drain();

    // Fill to DEPTH; full blocks issue even with a retire that cycle.
    for (int i = 0; i < 4; i++) begin issue(5'(10 + i), 1); tick(); end
    chk("t3_full", full, 1);
    chk("t3_count4", count, 4);
    issue(5'd14, 1); exu = 1; wb = 1; #1;
    chk("t3_full_stall", stall, 1);
    tick();
    chk("t3_count3", count, 3);
    chk("t3_not_full", full, 0);
    drain();

    // Flush with same-cycle exu_done keeps the resolving branch, drops younger work.
    issue(5'd1, 1); tick();
    issue(5'd2, 1); tick();
    issue(5'd3, 1); tick();
    idle(); exu = 1; tick();
    idle(); exu = 1; fl = 1; tick();
    chk("t4_count2", count, 2);
    issue(5'd4, 1); rs1 = 5'd3; rs1u = 1; #1;
    chk("t4_x3_gone", stall, 0);
    tick();
    drain();

    // Serial instruction waits for an empty queue.
    issue(5'd20, 1); tick();
    issue(5'd21, 1); tick();
    issue(5'd22, 1); iser = 1; exu = 1; #1;
    chk("t5_serial_stall2", stall, 1);
    tick();
    exu = 1; wb = 1; tick();
    exu = 0; wb = 1; #1;
    chk("t5_serial_stall1", stall, 1);
    tick();
    wb = 0; #1;
    chk("t5_serial_empty", empty, 1);
    chk("t5_serial_go", stall, 0);
    tick();
    issue(5'd23, 1); #1;
    chk("t5_next_issue", stall, 0);
    tick();
    drain();

    // Reset wins over push and flush.
    for (int i = 0; i < 3; i++) begin issue(5'(24 + i), 1); tick(); end
    issue(5'd27, 1); fl = 1; rst = 1; tick();
    chk("t6_count0", count, 0);
    chk("t6_empty", empty, 1);
    issue(5'd28, 1); rs1 = 5'd24; rs1u = 1; #1;
    chk("t6_stall_inputs", stall, 0);
    tick();
    drain();

    // Random legal traffic on a small register range to provoke hazards.
    for (int n = 0; n < 500; n++) begin
      idle();
      iv   = ($urandom_range(0, 3) != 0);
      ird  = 5'($urandom_range(0, 7));
      iwen = ($urandom_range(0, 3) != 0);
      iser = ($urandom_range(0, 9) == 0);
      rs1  = 5'($urandom_range(0, 7));
      rs1u = $urandom_range(0, 1);
      rs2  = 5'($urandom_range(0, 7));
      rs2u = $urandom_range(0, 1);
      exu  = has_unexed() && ($urandom_range(0, 1) == 1);
      wb   = (exp_q.size() > 0) && (exp_q[0][0] || exu) && ($urandom_range(0, 1) == 1);
      fl   = ($urandom_range(0, 11) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
